counter_column: RTL and testbench
=================================

Name: counter_column

Overview:
- Free-running modulo-N column index counter used to sequence column selection (e.g. scanning a memory or array column by column) in the SISD datapath.
- Advances once per rising clock edge and wraps from the last column back to 0.
- Also provides a one-hot column select and a last-column flag, both decoded from the count.

Parameters:
- NUM_COLS, 4, number of columns, i.e. the counter modulus. Legal range is ≥2.
- CW, 2, width of counter_val. Must satisfy 2^CW ≥ NUM_COLS. Default matches NUM_COLS=4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- counter_val  output  CW  current column index, registered.
- col_onehot  output  NUM_COLS  one-hot decode of counter_val; bit counter_val is 1.
- col_last  output  1  high while counter_val == NUM_COLS-1.

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high.
- Reset:
  - Sampled only on the rising edge of clk.
  - On an edge with reset=1, counter_val := 0 regardless of current value; no increment occurs that edge.
  - Reset outputs: counter_val=0, col_onehot=1 (bit0 set), col_last=0.
- Power-up: the counter register carries an initial value of 0, so it counts from 0 in simulation even if reset is never asserted. No X appears on counter_val.
- Counting:
  - On each rising edge with reset=0: if counter_val == NUM_COLS-1, counter_val := 0; else counter_val := counter_val+1.
  - No enable; counting is unconditional.
- Latency:
  - counter_val changes one edge after the condition that causes it.
  - A sampler on the same edge sees the pre-edge value (non-blocking update).
- Wrap boundary: NUM_COLS-1 -> 0 in one step. With the defaults the sequence is 0,1,2,3,0,1,...
- Non-power-of-2 NUM_COLS: values ≥ NUM_COLS are never produced. Wrap is an explicit compare, not natural overflow.
- Reset while counting (any value, including the wrap value): the next value is 0. Counting resumes +1 on the first edge with reset=0.
- Reset held for several cycles: counter_val stays 0 throughout.
- col_onehot and col_last:
  - Purely combinational from counter_val; no additional latency.
  - Exactly one bit of col_onehot is high at all times.

Decomposition:
- No shared package is required.
- A width helper (CW derivation) may go in the common package if one exists.
- Optional sub-module: col_decoder (counter_val -> col_onehot, col_last), parameterised by NUM_COLS and CW.
- The counter register stays in counter_column.

Test Plan:
- No reset asserted, clock 10-unit period, sample on each rising edge -> sampled counter_val is 0,1,2,3,0 on edges 1-5.
- Reset=1 for one edge when counter_val=0 after wrap -> counter_val stays 0. Release reset -> subsequent edges sample 0,1,2.
- Reset asserted when counter_val=2 -> next value 0, not 3. After release the count proceeds 1,2,3,0.
- Reset held for 3 edges -> counter_val=0 and col_onehot=4'b0001 on every edge.
- Decode check over a full cycle:
  - col_onehot is 0001,0010,0100,1000 for counter_val 0..3.
  - col_last=1 only at counter_val=3.
- NUM_COLS=3, CW=2 -> sequence 0,1,2,0. Value 3 is never produced; col_last is high at 2.

Source files
------------

// File: rtl/counter_column_pkg.sv
// Shared defaults and the width helper for the column counter.
package counter_column_pkg;

  localparam int DEF_NUM_COLS = 4;

  // Smallest width (at least 1) whose range covers n column indices.
  function automatic int col_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/counter_column_col_decoder.sv
// Decodes a column index into a one-hot select and a last-column flag.
module counter_column_col_decoder #(
  parameter int NUM_COLS = 4,
  parameter int CW       = 2
) (
  input  logic [CW-1:0]       counter_val,
  output logic [NUM_COLS-1:0] col_onehot,
  output logic                col_last
);

  localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);

  // One comparator per column; exactly one matches because the counter
  // never leaves 0..NUM_COLS-1.
  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    assign col_onehot[i] = (counter_val == CW'(i));
  end

  assign col_last = (counter_val == LAST);

endmodule

// File: rtl/counter_column.sv
// Free-running modulo-NUM_COLS column index counter with decoded selects.
module counter_column
  import counter_column_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int CW       = col_width(NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [CW-1:0]       counter_val,
  output logic [NUM_COLS-1:0] col_onehot,
  output logic                col_last
);

  localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);

  // Power-up value of 0 so the scan starts at column 0 without a reset.
  logic [CW-1:0] count = '0;

  // Explicit wrap compare so non-power-of-2 moduli never reach NUM_COLS.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign counter_val = count;

  counter_column_col_decoder #(
    .NUM_COLS (NUM_COLS),
    .CW       (CW)
  ) u_dec (
    .counter_val (count),
    .col_onehot  (col_onehot),
    .col_last    (col_last)
  );

endmodule

// File: tb/tb_counter_column.sv
// Checks the column counter at NUM_COLS=4 and NUM_COLS=3 against a
// directed table and a randomized modulo-arithmetic reference.
module tb_counter_column;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] cv4, cv3;
  logic [3:0] oh4;
  logic [2:0] oh3;
  logic       last4, last3;

  int n_checks = 0;
  int n_fail   = 0;
  int m4 = 0;
  int m3 = 0;

  always #5 clk = ~clk;

  counter_column #(.NUM_COLS(4), .CW(2)) dut4 (
    .clk(clk), .reset(reset),
    .counter_val(cv4), .col_onehot(oh4), .col_last(last4)
  );

  counter_column #(.NUM_COLS(3), .CW(2)) dut3 (
    .clk(clk), .reset(reset),
    .counter_val(cv3), .col_onehot(oh3), .col_last(last3)
  );

  typedef struct {
    bit rst;
    int exp4;
    int exp3;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare both instances against expected column indices e4 / e3.
  task automatic chk_all(input string tag, input int e4, input int e3);
    chk({tag, " cnt4"},  int'(cv4),   e4);
    chk({tag, " oh4"},   int'(oh4),   1 << e4);
    chk({tag, " last4"}, int'(last4), (e4 == 3) ? 1 : 0);
    chk({tag, " cnt3"},  int'(cv3),   e3);
    chk({tag, " oh3"},   int'(oh3),   1 << e3);
    chk({tag, " last3"}, int'(last3), (e3 == 2) ? 1 : 0);
    chk({tag, " ones4"}, $countones(oh4), 1);
    chk({tag, " ones3"}, $countones(oh3), 1);
  endtask

  // Drive reset for one edge, advance the reference model, sample after.
  task automatic step(input bit r);
    reset = r;
    @(posedge clk);
    m4 = r ? 0 : (m4 + 1) % 4;
    m3 = r ? 0 : (m3 + 1) % 3;
    #1;
  endtask

  initial begin
    // {reset for this edge, expected count4 after edge, expected count3}
    vecs = '{
      '{0, 1, 1}, '{0, 2, 2}, '{0, 3, 0}, '{0, 0, 1},  // free run + wraps
      '{1, 0, 0},                                      // reset at 0 after wrap
      '{0, 1, 1}, '{0, 2, 2},
      '{1, 0, 0},                                      // reset at 2, not 3
      '{0, 1, 1}, '{0, 2, 2}, '{0, 3, 0}, '{0, 0, 1},
      '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 0},              // reset held 3 edges
      '{0, 1, 1}, '{0, 2, 2},
      '{1, 0, 0},                                      // reset at N=3 wrap value
      '{0, 1, 1}, '{0, 2, 2}, '{0, 3, 0},
      '{1, 0, 0}                                       // reset at N=4 wrap value
    };

    // Power-up value without any reset.
    #1;
    chk_all("powerup", 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst);
      chk_all($sformatf("vec%0d", i), vecs[i].exp4, vecs[i].exp3);
    end

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 5) == 0);
      chk_all($sformatf("rand%0d", i), m4, m3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
